// File: rtl/data_memory_if.sv
// rtl/data_memory_if.sv - request/response bus between the memory-access stage and data_memory
interface data_memory_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [63:0] req_addr_i;
   logic [63:0] req_wdata_i;
   logic        resp_valid_o;
   logic        resp_ready_i;
   logic [63:0] resp_rdata_o;
   logic        resp_err_o;

   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
   );

   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
   );
endinterface

// File: rtl/data_memory.sv
// rtl/data_memory.sv - byte-addressed 64-bit data memory responder with fixed response latency
// DMEM_ALIGN_CHECK_EN: when defined, addresses not aligned to 8 bytes also report an error.
module data_memory #(
   parameter int unsigned DEPTH_BYTES = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   data_memory_if.slave  bus
);

   localparam int unsigned AW       = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
   localparam int unsigned CW       = $clog2(LATENCY) + 1;
   localparam logic [63:0] MAX_ADDR = 64'(DEPTH_BYTES - 8);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q;
   logic [63:0]    rdata_q;
   logic           err_q;
   logic [7:0]     mem [DEPTH_BYTES];
   logic           accept;
   logic           addr_err;
   logic [AW-1:0]  base;

   assign accept = bus.req_valid_i & bus.req_ready_o;
   assign base   = bus.req_addr_i[AW-1:0];

   // Full 64-bit compare so addresses near 2^64 cannot wrap back into range.
   always_comb begin
      addr_err = (bus.req_addr_i > MAX_ADDR);
`ifdef DMEM_ALIGN_CHECK_EN
      if (bus.req_addr_i[2:0] != 3'b000) addr_err = 1'b1;
`endif
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = (LATENCY > 1) ? WAIT : RESP;
         WAIT:    if (cnt_q == CW'(1)) state_d = RESP;
         RESP:    if (bus.resp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready_o  = (state_q == IDLE) & ~rst_i;
      bus.resp_valid_o = (state_q == RESP);
      bus.resp_rdata_o = rdata_q;
      bus.resp_err_o   = err_q;
   end

   // Writes commit and reads sample at the accept edge; the FSM only paces the response.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(DEPTH_BYTES); i++) mem[i] <= 8'h00;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         if (accept) begin
            err_q   <= addr_err;
            rdata_q <= '0;
            cnt_q   <= CW'(LATENCY - 1);
            if (!addr_err) begin
               if (bus.req_we_i) begin
                  for (int i = 0; i < 8; i++) mem[base + AW'(i)] <= bus.req_wdata_i[8*i +: 8];
               end else begin
                  for (int i = 0; i < 8; i++) rdata_q[8*i +: 8] <= mem[base + AW'(i)];
               end
            end
         end else if (state_q == WAIT) begin
            cnt_q <= cnt_q - CW'(1);
         end else if ((state_q == RESP) && bus.resp_ready_i) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - self-checking bench for data_memory against a byte-array reference model
module tb_data_memory;
   localparam int unsigned DEPTH = 1024;
   localparam int unsigned LAT   = 2;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;

   logic [7:0] ref_mem [DEPTH];

   data_memory_if bus();

   data_memory #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic clear_ref();
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 8'h00;
   endtask

   // Reference: an access is legal when all 8 bytes lie inside the memory.
   task automatic ref_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                          output logic [63:0] exp_rdata, output logic exp_err);
      int a;
      exp_rdata = '0;
      exp_err   = (addr + 64'd0 > 64'(DEPTH - 8));
`ifdef DMEM_ALIGN_CHECK_EN
      if (addr % 8 != 0) exp_err = 1'b1;
`endif
      if (!exp_err) begin
         a = int'(addr[31:0]);
         for (int i = 0; i < 8; i++) begin
            if (we) ref_mem[a + i] = wdata[8*i +: 8];
            else    exp_rdata[8*i +: 8] = ref_mem[a + i];
         end
      end
   endtask

   // Called at a negedge with the DUT idle; ends at a negedge after the response handshake.
   task automatic xact(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input int stall, output logic [63:0] rdata, output logic err);
      int n;
      int lat;
      bus.req_valid_i  = 1'b1;
      bus.req_we_i     = we;
      bus.req_addr_i   = addr;
      bus.req_wdata_i  = wdata;
      bus.resp_ready_i = (stall == 0);
      n = 0;
      while (!bus.req_ready_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      chk("accept_in_time", 64'(n < 20), 64'd1);
      @(posedge clk_i);
      #1;
      bus.req_valid_i = 1'b0;
      lat = 0;
      do begin
         @(negedge clk_i);
         lat++;
      end while (!bus.resp_valid_o && lat < 20);
      chk("latency", 64'(lat), 64'(LAT));
      rdata = bus.resp_rdata_o;
      err   = bus.resp_err_o;
      for (int s = 0; s < stall; s++) begin
         // A request while busy must be ignored.
         bus.req_valid_i = 1'b1;
         bus.req_we_i    = 1'b1;
         bus.req_addr_i  = 64'h0;
         bus.req_wdata_i = '1;
         @(negedge clk_i);
         chk("hold_valid", 64'(bus.resp_valid_o), 64'd1);
         chk("hold_rdata", bus.resp_rdata_o, rdata);
         chk("hold_ready", 64'(bus.req_ready_o), 64'd0);
      end
      bus.resp_ready_i = 1'b1;
      @(negedge clk_i);
      bus.req_valid_i  = 1'b0;
      bus.resp_ready_i = 1'b0;
      chk("post_hs_valid", 64'(bus.resp_valid_o), 64'd0);
      chk("post_hs_ready", 64'(bus.req_ready_o), 64'd1);
      chk("post_hs_rdata", bus.resp_rdata_o, 64'd0);
   endtask

   task automatic run(input string tag, input logic we, input logic [63:0] addr,
                      input logic [63:0] wdata, input int stall,
                      output logic [63:0] got_rdata, output logic got_err);
      logic [63:0] exp_rdata;
      logic        exp_err;
      ref_txn(we, addr, wdata, exp_rdata, exp_err);
      xact(we, addr, wdata, stall, got_rdata, got_err);
      chk({tag, "_rdata"}, got_rdata, exp_rdata);
      chk({tag, "_err"}, 64'(got_err), 64'(exp_err));
   endtask

   initial begin
      logic [63:0] rd;
      logic        er;
      logic [63:0] addr;
      logic        we;
      int          n;

      bus.req_valid_i  = 1'b0;
      bus.req_we_i     = 1'b0;
      bus.req_addr_i   = '0;
      bus.req_wdata_i  = '0;
      bus.resp_ready_i = 1'b0;
      clear_ref();

      // Reset held for two cycles
      rst_i = 1'b1;
      repeat (2) @(negedge clk_i);
      chk("rst_ready", 64'(bus.req_ready_o), 64'd0);
      chk("rst_valid", 64'(bus.resp_valid_o), 64'd0);
      chk("rst_rdata", bus.resp_rdata_o, 64'd0);
      chk("rst_err", 64'(bus.resp_err_o), 64'd0);
      rst_i = 1'b0;
      #1;
      chk("idle_ready", 64'(bus.req_ready_o), 64'd1);
      @(negedge clk_i);
      run("rst_read0", 1'b0, 64'h0, 64'h0, 0, rd, er);
      chk("rst_read0_zero", rd, 64'h0);

      // Write then read
      run("wr10", 1'b1, 64'h10, 64'h1122334455667788, 0, rd, er);
      run("rd10", 1'b0, 64'h10, 64'h0, 0, rd, er);
      chk("rd10_const", rd, 64'h1122334455667788);
      chk("rd10_lowbyte", 64'(rd[7:0]), 64'h88);

      // Range edge
      run("wr3f8", 1'b1, 64'h3F8, 64'hA5A5A5A5A5A5A5A5, 0, rd, er);
      chk("wr3f8_ok", 64'(er), 64'd0);
      run("wr3f9", 1'b1, 64'h3F9, 64'h0123456789ABCDEF, 0, rd, er);
      chk("wr3f9_err", 64'(er), 64'd1);
      run("rd3f8", 1'b0, 64'h3F8, 64'h0, 0, rd, er);
      chk("rd3f8_unchanged", rd, 64'hA5A5A5A5A5A5A5A5);
      run("rdmax", 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 0, rd, er);
      chk("rdmax_err", 64'(er), 64'd1);

      // Backpressure, with a stray write to 0x0 offered while busy
      run("bp", 1'b0, 64'h10, 64'h0, 5, rd, er);
      run("bp_stray", 1'b0, 64'h0, 64'h0, 0, rd, er);
      chk("bp_stray_zero", rd, 64'h0);

      // Reset while the write is in flight
      bus.req_valid_i  = 1'b1;
      bus.req_we_i     = 1'b1;
      bus.req_addr_i   = 64'h20;
      bus.req_wdata_i  = 64'hDEAD;
      bus.resp_ready_i = 1'b1;
      chk("mid_ready", 64'(bus.req_ready_o), 64'd1);
      @(posedge clk_i);
      #1;
      bus.req_valid_i = 1'b0;
      @(negedge clk_i);
      chk("mid_wait_valid", 64'(bus.resp_valid_o), 64'd0);
      rst_i = 1'b1;
      #1;
      chk("mid_rst_ready", 64'(bus.req_ready_o), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      bus.resp_ready_i = 1'b0;
      clear_ref();
      n = 0;
      repeat (4) begin
         @(negedge clk_i);
         if (bus.resp_valid_o) n++;
      end
      chk("mid_no_resp", 64'(n), 64'd0);
      chk("mid_ready_after", 64'(bus.req_ready_o), 64'd1);
      run("mid_rd20", 1'b0, 64'h20, 64'h0, 0, rd, er);
      chk("mid_rd20_zero", rd, 64'h0);

      // Unaligned access
      run("wr20", 1'b1, 64'h20, 64'h8877665544332211, 0, rd, er);
      run("wr28", 1'b1, 64'h28, 64'h00000000000000AB, 0, rd, er);
      run("rd21", 1'b0, 64'h21, 64'h0, 0, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
      chk("rd21_err", 64'(er), 64'd1);
      chk("rd21_rdata", rd, 64'h0);
`else
      chk("rd21_err", 64'(er), 64'd0);
      chk("rd21_rdata", rd, 64'hAB88776655443322);
`endif

      // Randomized traffic against the model
      for (int k = 0; k < 40; k++) begin
         we = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       addr = 64'($urandom_range(0, 127) * 8);
            1:       addr = 64'($urandom_range(0, 1016));
            2:       addr = 64'($urandom_range(1010, 1030));
            default: addr = {$urandom, $urandom};
         endcase
         run("rand", we, addr, {$urandom, $urandom}, int'($urandom_range(0, 2)), rd, er);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
